// File: rtl/crabmem_if.sv
// crabmem bus: core-to-memory request/response signals.
// master = core side, slave = memory side.
interface crabmem_if;
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic [31:0] mem_data;
  logic        mem_data_valid;
  logic [2:0]  io_mode;
  logic [31:0] mem_input;
  logic        mem_ready;
  logic        mem_write_done;
  logic        mem_fault;

  modport master (
    output mem_addr, mem_addr_valid,
    output mem_data, mem_data_valid,
    output io_mode,
    input  mem_input, mem_ready,
    input  mem_write_done, mem_fault
  );

  modport slave (
    input  mem_addr, mem_addr_valid,
    input  mem_data, mem_data_valid,
    input  io_mode,
    output mem_input, mem_ready,
    output mem_write_done, mem_fault
  );
endinterface

// File: rtl/crabmem.sv
// crabmem: single-port word RAM slave for the crabcore bus with
// byte-lane stores, extended loads and LATENCY wait cycles.
// Ports: clk, reset (async, active-low), bus (crabmem_if.slave).
// Build option: define CRABMEM_FAULT_EN to reject misaligned and
// out-of-range requests with a mem_fault pulse.
module crabmem #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic      clk,
  input  logic      reset,
  crabmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RECOVER
  } state_t;

  state_t        st;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic [2:0]    mode_q;
  logic          we_q;
  logic [31:0]   rdata_q;
  logic          rdy_q;
  logic          wd_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    sz;
  logic [31:0]   rword;
  logic [31:0]   sh_b;
  logic [31:0]   sh_h;
  logic [31:0]   ld;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          access;
  logic          flt;
  logic          commit;

  assign idx    = addr_q[AW+1:2];
  assign sz     = mode_q[1:0];
  assign rword  = mem[idx];
  assign sh_b   = rword >> {addr_q[1:0], 3'b000};
  assign sh_h   = rword >> {addr_q[1], 4'b0000};
  assign access = (st == BUSY) && (cnt == 4'd0);

`ifdef CRABMEM_FAULT_EN
  logic oob_q;
  logic flt_q;
  logic mis;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (sz == 2'd0): mis = 1'b0;
      (sz == 2'd1): mis = addr_q[0];
      default:      mis = addr_q[1:0] != 2'b00;
    endcase
  end

  assign flt           = mis | oob_q;
  assign bus.mem_fault = flt_q;
`else
  assign flt           = 1'b0;
  assign bus.mem_fault = 1'b0;
`endif

  assign commit = access & we_q & ~flt;

  // Lane enables and lane-replicated store data; misaligned
  // accesses fall onto the aligned lanes of their size.
  always_comb begin
    be    = 4'b1111;
    wdata = data_q;
    ld    = rword;
    unique case (1'b1)
      (sz == 2'd0): begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{data_q[7:0]}};
        ld    = {{24{~mode_q[2] & sh_b[7]}}, sh_b[7:0]};
      end
      (sz == 2'd1): begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
        ld    = {{16{~mode_q[2] & sh_h[15]}}, sh_h[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wdata = data_q;
        ld    = rword;
      end
    endcase
  end

  // RAM array is never reset; commit is forced low by reset
  // because st is held in IDLE.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      wd_q    <= 1'b0;
`ifdef CRABMEM_FAULT_EN
      oob_q   <= 1'b0;
      flt_q   <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
      wd_q  <= 1'b0;
`ifdef CRABMEM_FAULT_EN
      flt_q <= 1'b0;
`endif
      unique case (st)
        IDLE: begin
          if (bus.mem_addr_valid) begin
            addr_q <= bus.mem_addr[AW+1:0];
            data_q <= bus.mem_data;
            mode_q <= bus.io_mode;
            we_q   <= bus.mem_data_valid;
            cnt    <= 4'(LATENCY - 1);
            st     <= BUSY;
`ifdef CRABMEM_FAULT_EN
            oob_q  <= |bus.mem_addr[31:AW+2];
`endif
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            st <= RESP;
            if (flt) begin
`ifdef CRABMEM_FAULT_EN
              flt_q <= 1'b1;
`endif
            end else if (we_q) begin
              wd_q <= 1'b1;
            end else begin
              rdy_q   <= 1'b1;
              rdata_q <= ld;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    st <= RECOVER;
        RECOVER: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.mem_input      = rdata_q;
  assign bus.mem_ready      = rdy_q;
  assign bus.mem_write_done = wd_q;

endmodule
